fetch_unit: RTL

Instruction fetch sequencer that sits on the consumer side of the program counter register. Each cycle it reads the current PC, issues a request/acknowledge read to instruction memory and holds the fetched word for the decoder under a valid/ready handshake. It also computes and drives the next PC value and its write enable back into the counter, either PC+1 or a branch redirect target.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads the PC, fetches from instruction memory
// over a req/ack interface, presents the word to the decoder under valid/ready,
// and drives the next PC (PC+1 or a branch redirect) back into the counter.
module fetch_unit #(
  parameter int unsigned ADDRESS_LENGTH = 16,
  parameter int unsigned INSTR_WIDTH    = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [ADDRESS_LENGTH-1:0] PCReadAddr,
  output logic [ADDRESS_LENGTH-1:0] PCWriteAddr,
  output logic                      PCEnable,
  output logic                      MemReq,
  output logic [ADDRESS_LENGTH-1:0] MemAddr,
  input  logic                      MemAck,
  input  logic [INSTR_WIDTH-1:0]    MemData,
  output logic [INSTR_WIDTH-1:0]    Instr,
  output logic                      InstrValid,
  input  logic                      InstrReady,
  input  logic                      BranchTaken,
  input  logic [ADDRESS_LENGTH-1:0] BranchTarget
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      instr_valid_q, instr_valid_d;
  logic                      mem_req_q, mem_req_d;
  logic                      pend_q, pend_d;
  logic [ADDRESS_LENGTH-1:0] pend_addr_q, pend_addr_d;
  logic [ADDRESS_LENGTH-1:0] pc_inc_c;
  logic                      pc_en_c;
  logic [ADDRESS_LENGTH-1:0] pc_wr_addr_c;

  // Sequential PC successor, wraps modulo 2^ADDRESS_LENGTH
  always_comb begin
    pc_inc_c = PCReadAddr + ADDRESS_LENGTH'(1);
  end

  // Next-state, datapath and PC-update decode
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pc_en_c      = 1'b0;
    pc_wr_addr_c = pc_inc_c;

    case (state_q)
      START: begin
        state_d = FETCH;
        if (BranchTaken) begin
          pc_en_c      = 1'b1;
          pc_wr_addr_c = BranchTarget;
        end
      end

      FETCH: begin
        if (MemAck) begin
          if (pend_q || BranchTaken) begin
            // Returned word belongs to a squashed path: drop it and redirect
            pc_en_c      = 1'b1;
            pc_wr_addr_c = BranchTaken ? BranchTarget : pend_addr_q;
            pend_d       = 1'b0;
          end else begin
            instr_d = MemData;
            state_d = VALID;
          end
        end else if (BranchTaken) begin
          // Request cannot be withdrawn; remember the newest target
          pend_d      = 1'b1;
          pend_addr_d = BranchTarget;
        end
      end

      VALID: begin
        if (BranchTaken) begin
          pc_en_c      = 1'b1;
          pc_wr_addr_c = BranchTarget;
          state_d      = FETCH;
        end else if (InstrReady) begin
          pc_en_c = 1'b1;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = START;
      end
    endcase

    mem_req_d     = (state_d == FETCH);
    instr_valid_d = (state_d == VALID);
  end

  // State and holding registers, cleared asynchronously by Rst
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= START;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      mem_req_q     <= mem_req_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
    end
  end

  assign PCEnable    = pc_en_c;
  assign PCWriteAddr = pc_wr_addr_c;
  assign MemReq      = mem_req_q;
  assign MemAddr     = PCReadAddr;
  assign Instr       = instr_q;
  assign InstrValid  = instr_valid_q;

endmodule
